osc_recursive_mc: RTL

//  Time-multiplexed, multi-channel 2nd-order recursive sine generator: y[n] = coef*y[n-1] - y[n-2], with coef = 2cos(w).
//  One shared MAC serves NCH channels, one channel per cycle. Per-channel retune is queued and applied at the next

---
 rtl/osc_pkg.sv | 36 +++
 rtl/osc_mac.sv | 35 +++
 rtl/osc_recursive_mc.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/osc_pkg.sv
// Shared types and helpers for the multi-channel recursive oscillator.
// Config opcodes, scan FSM states and the output saturation helper.
package osc_pkg;

  typedef enum logic [1:0] {
    OP_RETUNE = 2'b00,
    OP_LOAD   = 2'b01,
    OP_STOP   = 2'b10,
    OP_RSVD   = 2'b11
  } cfg_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  // Clamp a wide signed value to the w-bit signed range (w <= 64).
  function automatic logic [63:0] sat_w(
    input logic signed [65:0] v,
    input int unsigned        w
  );
    logic signed [65:0] hi;
    logic signed [65:0] lo;
    logic signed [65:0] r;
    hi = (66'sd1 <<< (w - 1)) - 66'sd1;
    lo = -(66'sd1 <<< (w - 1));
    if (v > hi)
      r = hi;
    else if (v < lo)
      r = lo;
    else
      r = v;
    return r[63:0];
  endfunction

endpackage

// File: rtl/osc_mac.sv
// Shared multiply-accumulate for the recursive oscillator.
// y = sat(((coef*y1) >>> FRAC) - y2), computed wide enough to never wrap.
module osc_mac
  import osc_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 29
) (
  input  logic signed [W-1:0] coef,
  input  logic signed [W-1:0] y1,
  input  logic signed [W-1:0] y2,
  output logic signed [W-1:0] y
);

  localparam int PW = 2 * W;
  localparam int DW = 2 * W + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shf;
  logic signed [DW-1:0] diff;
  logic        [63:0]   sat;
  logic                 unused_sat;

  // Full-precision product, scale back to sample units, subtract, clamp.
  always_comb begin
    prod = PW'(coef) * PW'(y1);
    shf  = prod >>> FRAC;
    diff = DW'(shf) - DW'(y2);
    sat  = sat_w(66'(diff), W);
    y    = sat[W-1:0];
  end

  assign unused_sat = ^sat[63:W];

endmodule

// File: rtl/osc_recursive_mc.sv
// Time-multiplexed multi-channel recursive sine generator.
// One MAC serves all channels; retunes wait for a zero crossing.
module osc_recursive_mc
  import osc_pkg::*;
#(
  parameter int W       = 32,
  parameter int FRAC    = 29,
  parameter int NCH     = 4,
  parameter int ZC_BITS = 9,
  parameter int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                Fg_clk,
  input  logic                Resetn,
  input  logic                Enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [1:0]          cfg_op,
  input  logic [W-1:0]        cfg_coef,
  input  logic [W-1:0]        cfg_seed,
  output logic                out_valid,
  output logic [CHW-1:0]      out_ch,
  output logic signed [W-1:0] out_data,
  output logic                busy,
  output logic                overrun
);

  state_e         state_q, state_d;
  logic [CHW-1:0] cnt_q, cnt_d;
  logic           tick_pend_q, tick_pend_d;
  logic           overrun_d;
  logic           last;

  logic signed [W-1:0] y1_q   [NCH];
  logic signed [W-1:0] y2_q   [NCH];
  logic signed [W-1:0] coef_q [NCH];
  logic signed [W-1:0] scoef_q[NCH];
  logic signed [W-1:0] sseed_q[NCH];
  cfg_op_e             sop_q  [NCH];
  logic [NCH-1:0]      pend_q;
  logic [NCH-1:0]      act_q;

  logic signed [W-1:0] cy1, cy2, ccoef, scoef, sseed, step, tune_y;
  logic signed [W-1:0] nx_y1, nx_y2, nx_coef, nx_out;
  logic signed [W:0]   ext, mag;
  logic                cact, cpend, zc, nx_act, nx_pend;
  logic                is_stop, is_load, is_tune, is_rsvd;
  cfg_op_e             cop;

  assign busy      = (state_q == S_SCAN);
  assign cfg_ready = ~pend_q[cfg_ch];
  assign last      = (cnt_q == CHW'(NCH - 1));

  // Scan sequencing: one channel per cycle, one queued tick, overrun on a second.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tick_pend_d = tick_pend_q;
    overrun_d   = overrun;
    unique case (state_q)
      S_IDLE: begin
        if (Enable | tick_pend_q) begin
          state_d     = S_SCAN;
          cnt_d       = '0;
          tick_pend_d = Enable & tick_pend_q;
        end
      end
      S_SCAN: begin
        if (last) begin
          cnt_d = '0;
          if (Enable | tick_pend_q)
            tick_pend_d = Enable & tick_pend_q;
          else
            state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CHW'(1);
          if (Enable) begin
            if (tick_pend_q)
              overrun_d = 1'b1;
            else
              tick_pend_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, scan counter and tick bookkeeping registers.
  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tick_pend_q <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tick_pend_q <= tick_pend_d;
      overrun     <= overrun_d;
    end
  end

  assign cy1   = y1_q[cnt_q];
  assign cy2   = y2_q[cnt_q];
  assign ccoef = coef_q[cnt_q];
  assign scoef = scoef_q[cnt_q];
  assign sseed = sseed_q[cnt_q];
  assign cop   = sop_q[cnt_q];
  assign cact  = act_q[cnt_q];
  assign cpend = pend_q[cnt_q];

  osc_mac #(.W(W), .FRAC(FRAC)) u_mac (
    .coef (ccoef),
    .y1   (cy1),
    .y2   (cy2),
    .y    (step)
  );

  assign ext     = (W+1)'(cy1);
  assign mag     = ext[W] ? -ext : ext;
  assign zc      = mag < ((W+1)'(1) <<< (W - ZC_BITS));
  assign tune_y  = cy2[W-1] ? sseed : -sseed;
  assign is_stop = (cop == OP_STOP);
  assign is_load = (cop == OP_LOAD) | ((cop == OP_RETUNE) & ~cact);
  assign is_tune = (cop == OP_RETUNE) & cact & zc;
  assign is_rsvd = (cop == OP_RSVD);

  // Next state of the channel under the scan pointer.
  always_comb begin
    nx_y1   = cy1;
    nx_y2   = cy2;
    nx_coef = ccoef;
    nx_act  = cact;
    nx_pend = cpend;
    nx_out  = '0;
    if (cact) begin
      nx_y1  = step;
      nx_y2  = cy1;
      nx_out = step;
    end
    if (cpend) begin
      unique case (1'b1)
        is_stop: begin
          nx_y1   = '0;
          nx_y2   = '0;
          nx_coef = '0;
          nx_act  = 1'b0;
          nx_pend = 1'b0;
          nx_out  = '0;
        end
        is_load: begin
          nx_y1   = sseed;
          nx_y2   = '0;
          nx_coef = scoef;
          nx_act  = 1'b1;
          nx_pend = 1'b0;
          nx_out  = sseed;
        end
        is_tune: begin
          nx_y1   = tune_y;
          nx_y2   = '0;
          nx_coef = scoef;
          nx_pend = 1'b0;
          nx_out  = tune_y;
        end
        is_rsvd: nx_pend = 1'b0;
        default: ;
      endcase
    end
  end

  // Per-channel state write-back and config slot capture.
  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NCH; i++) begin
        y1_q[i]    <= '0;
        y2_q[i]    <= '0;
        coef_q[i]  <= '0;
        scoef_q[i] <= '0;
        sseed_q[i] <= '0;
        sop_q[i]   <= OP_RETUNE;
      end
      pend_q <= '0;
      act_q  <= '0;
    end else begin
      if (state_q == S_SCAN) begin
        y1_q[cnt_q]   <= nx_y1;
        y2_q[cnt_q]   <= nx_y2;
        coef_q[cnt_q] <= nx_coef;
        act_q[cnt_q]  <= nx_act;
        pend_q[cnt_q] <= nx_pend;
      end
      if (cfg_valid && cfg_ready) begin
        sop_q[cfg_ch]   <= cfg_op_e'(cfg_op);
        scoef_q[cfg_ch] <= cfg_coef;
        sseed_q[cfg_ch] <= cfg_seed;
        pend_q[cfg_ch]  <= 1'b1;
      end
    end
  end

  // Registered sample output, one channel per scan cycle.
  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= (state_q == S_SCAN);
      if (state_q == S_SCAN) begin
        out_ch   <= cnt_q;
        out_data <= nx_out;
      end
    end
  end

endmodule
